// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
// Shared MIPS ISA constants for the instruction encoder and the matching decoder:
// primary opcodes, R-type funct codes, the encoder's op_sel enumeration and the
// loader FSM state type.
package mips_isa_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OpcRtype = 6'h00;
    localparam logic [5:0] OpcAddi  = 6'h08;
    localparam logic [5:0] OpcAndi  = 6'h0C;
    localparam logic [5:0] OpcSw    = 6'h2B;
    localparam logic [5:0] OpcLw    = 6'h23;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnAdd = 6'h20;

    // Symbolic instruction selector presented by the host
    typedef enum logic [2:0] {
        OpSll     = 3'd0,
        OpOr      = 3'd1,
        OpAdd     = 3'd2,
        OpAddi    = 3'd3,
        OpAndi    = 3'd4,
        OpSw      = 3'd5,
        OpLw      = 3'd6,
        OpIllegal = 3'd7
    } op_sel_e;

    // Loader session state
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StFull  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if
// Request handshake (host -> encoder) and instruction-memory write bus
// (encoder -> memory) bundled into one interface.
//   master : host / bench side   (drives request, observes ready + write bus)
//   slave  : encoder side        (consumes request, drives ready + write bus)
// Signals: in_valid, in_ready, op_sel[2:0], rs/rt/rd/shamt[4:0], imm[15:0],
//          mem_we, mem_addr[ADDR_WIDTH-1:0], mem_wdata[31:0]
interface mips_instr_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op_sel;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [15:0]           imm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, op_sel, rs, rt, rd, shamt, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, shamt, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_field_packer.sv
// instr_field_packer
// Purely combinational: packs op_sel plus register/immediate fields into a
// 32-bit MIPS word. illegal_o flags op_sel values with no encoding (word_o = 0).
// Ports: op_sel_i[2:0], rs_i/rt_i/rd_i/shamt_i[4:0], imm_i[15:0]
//        -> word_o[31:0], illegal_o
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  logic [2:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (op_sel_e'(op_sel_i))
            // sll has no rs operand; or/add have no shift amount
            OpSll:  word_o = {OpcRtype, 5'd0, rt_i, rd_i, shamt_i, FnSll};
            OpOr:   word_o = {OpcRtype, rs_i, rt_i, rd_i, 5'd0, FnOr};
            OpAdd:  word_o = {OpcRtype, rs_i, rt_i, rd_i, 5'd0, FnAdd};
            OpAddi: word_o = {OpcAddi, rs_i, rt_i, imm_i};
            OpAndi: word_o = {OpcAndi, rs_i, rt_i, imm_i};
            OpSw:   word_o = {OpcSw, rs_i, rt_i, imm_i};
            OpLw:   word_o = {OpcLw, rs_i, rt_i, imm_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Sequential instruction encoder / program loader. Accepts symbolic requests on
// bus (slave modport), encodes them and writes them to consecutive instruction
// memory word addresses starting at BASE_ADDR.
// Ports: clk, reset (async active-low), start, finish, bus (request + write bus),
//        instr_count[ADDR_WIDTH:0], full, err_illegal, load_done
// Build option: define ENCODER_NOP_PAD_EN to append one 0x00000000 terminator
// word on finish when space remains.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    finish,
    mips_instr_encoder_if.slave     bus,
    output logic [ADDR_WIDTH:0]     instr_count,
    output logic                    full,
    output logic                    err_illegal,
    output logic                    load_done
);

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    enc_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;        // next address to write
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic                  load_done_q, load_done_d;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        in_ready;
    logic        accept;

    instr_field_packer u_packer (
        .op_sel_i  (bus.op_sel),
        .rs_i      (bus.rs),
        .rt_i      (bus.rt),
        .rd_i      (bus.rd),
        .shamt_i   (bus.shamt),
        .imm_i     (bus.imm),
        .word_o    (packed_word),
        .illegal_o (packed_illegal)
    );

    // start/finish take the cycle, so no handshake can coincide with them
    assign in_ready = (state_q == StLoad) && !start && !finish;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        load_done_d = 1'b0;

        if (start) begin
            // Rewind the session; a registered write not yet issued is dropped
            state_d    = StLoad;
            ptr_d      = BaseAddr;
            mem_addr_d = BaseAddr;
            count_d    = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    if (finish) begin
                        state_d = StDrain;
`ifdef ENCODER_NOP_PAD_EN
                        // Terminator is registered here so it strobes during DRAIN
                        if (!full_q) begin
                            we_d       = 1'b1;
                            mem_addr_d = ptr_q;
                            ptr_d      = ptr_q + 1'b1;
                            wdata_d    = 32'h0;
                            count_d    = count_q + 1'b1;
                        end
`endif
                    end else if (accept) begin
                        if (packed_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            we_d       = 1'b1;
                            mem_addr_d = ptr_q;
                            ptr_d      = ptr_q + 1'b1;
                            wdata_d    = packed_word;
                            count_d    = count_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (finish) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    // Leave only after any write strobe in flight has completed
                    if (!we_q) begin
                        state_d     = StIdle;
                        load_done_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Count reaching 2^ADDR_WIDTH means every slot has been written
            if (we_d && count_d[ADDR_WIDTH]) begin
                full_d = 1'b1;
                if (state_d == StLoad) begin
                    state_d = StFull;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= BaseAddr;
            mem_addr_q  <= BaseAddr;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            load_done_q <= load_done_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wdata_q;
    assign instr_count   = count_q;
    assign full          = full_q;
    assign err_illegal   = err_q;
    assign load_done     = load_done_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
// Directed bench for mips_instr_encoder. Two instances share one stimulus
// stream: u_dut (ADDR_WIDTH=8) for encoding/sequencing and u_small
// (ADDR_WIDTH=2) for memory-exhaustion behaviour. Inputs change and outputs
// are sampled 1 ns after the falling edge.
module tb_mips_instr_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        finish;
    logic        in_valid;
    logic [2:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    logic [8:0]  cnt_a;
    logic        full_a, err_a, done_a;
    logic [2:0]  cnt_s;
    logic        full_s, err_s, done_s;

    int tests;
    int fails;

    mips_instr_encoder_if #(.ADDR_WIDTH(8)) bus_a ();
    mips_instr_encoder_if #(.ADDR_WIDTH(2)) bus_s ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.op_sel   = op_sel;
    assign bus_a.rs       = rs;
    assign bus_a.rt       = rt;
    assign bus_a.rd       = rd;
    assign bus_a.shamt    = shamt;
    assign bus_a.imm      = imm;
    assign bus_s.in_valid = in_valid;
    assign bus_s.op_sel   = op_sel;
    assign bus_s.rs       = rs;
    assign bus_s.rt       = rt;
    assign bus_s.rd       = rd;
    assign bus_s.shamt    = shamt;
    assign bus_s.imm      = imm;

    mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .bus         (bus_a),
        .instr_count (cnt_a),
        .full        (full_a),
        .err_illegal (err_a),
        .load_done   (done_a)
    );

    mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_small (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .bus         (bus_s),
        .instr_count (cnt_s),
        .full        (full_s),
        .err_illegal (err_s),
        .load_done   (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im);
        op_sel   = op;
        rs       = s;
        rt       = t;
        rd       = d;
        shamt    = sh;
        imm      = im;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        finish   = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
        op_sel   = 3'd0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        shamt    = '0;
        imm      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_load_done", 32'(done_a), 32'd0);
        reset = 1'b1;
        idle_cycle();
        check("idle_in_ready", 32'(bus_a.in_ready), 32'd0);

        // addi $8, $0, 5
        do_start();
        check("start_in_ready", 32'(bus_a.in_ready), 32'd1);
        check("start_count", 32'(cnt_a), 32'd0);
        send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005);
        check("addi_we", 32'(bus_a.mem_we), 32'd1);
        check("addi_addr", 32'(bus_a.mem_addr), 32'd0);
        check("addi_data", bus_a.mem_wdata, 32'h2008_0005);
        check("addi_count", 32'(cnt_a), 32'd1);
        idle_cycle();
        check("strobe_one_cycle", 32'(bus_a.mem_we), 32'd0);

        // Back-to-back add / sll (rs forced to 0), then lw, sw, or, andi
        do_start();
        send(3'd2, 5'd9, 5'd10, 5'd8, 5'd0, 16'h0);
        check("add_we", 32'(bus_a.mem_we), 32'd1);
        check("add_addr", 32'(bus_a.mem_addr), 32'd0);
        check("add_data", bus_a.mem_wdata, 32'h012A_4020);
        send(3'd0, 5'd7, 5'd9, 5'd8, 5'd2, 16'h0);
        check("sll_we", 32'(bus_a.mem_we), 32'd1);
        check("sll_addr", 32'(bus_a.mem_addr), 32'd1);
        check("sll_data", bus_a.mem_wdata, 32'h0009_4080);
        check("sll_count", 32'(cnt_a), 32'd2);
        send(3'd6, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        check("lw_addr", 32'(bus_a.mem_addr), 32'd2);
        check("lw_data", bus_a.mem_wdata, 32'h8FA8_0004);
        send(3'd5, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0008);
        check("sw_addr", 32'(bus_a.mem_addr), 32'd3);
        check("sw_data", bus_a.mem_wdata, 32'hAFA8_0008);
        send(3'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0);
        check("or_addr", 32'(bus_a.mem_addr), 32'd4);
        check("or_data", bus_a.mem_wdata, 32'h0022_1825);
        send(3'd4, 5'd1, 5'd2, 5'd3, 5'd9, 16'hFFFF);
        check("andi_addr", 32'(bus_a.mem_addr), 32'd5);
        check("andi_data", bus_a.mem_wdata, 32'h3022_FFFF);
        check("andi_count", 32'(cnt_a), 32'd6);
        idle_cycle();

        // Illegal op between two adds
        do_start();
        send(3'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        check("ill_pre_addr", 32'(bus_a.mem_addr), 32'd0);
        check("ill_pre_data", bus_a.mem_wdata, 32'h0022_1820);
        send(3'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        check("ill_no_we", 32'(bus_a.mem_we), 32'd0);
        check("ill_err", 32'(err_a), 32'd1);
        check("ill_count", 32'(cnt_a), 32'd1);
        send(3'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        check("ill_post_we", 32'(bus_a.mem_we), 32'd1);
        check("ill_post_addr", 32'(bus_a.mem_addr), 32'd1);
        check("ill_post_data", bus_a.mem_wdata, 32'h0085_3020);
        check("ill_post_count", 32'(cnt_a), 32'd2);
        idle_cycle();
        check("err_sticky", 32'(err_a), 32'd1);
        do_start();
        check("restart_err", 32'(err_a), 32'd0);
        check("restart_addr", 32'(bus_a.mem_addr), 32'd0);
        check("restart_count", 32'(cnt_a), 32'd0);

        // finish while the last write strobe is in flight
        send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005);
        check("fin_write_we", 32'(bus_a.mem_we), 32'd1);
        in_valid = 1'b0;
        finish   = 1'b1;
        #1;
        check("fin_in_ready", 32'(bus_a.in_ready), 32'd0);
        @(negedge clk);
        finish = 1'b0;
        #1;
        check("drain_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("drain_done0", 32'(done_a), 32'd0);
`ifdef ENCODER_NOP_PAD_EN
        check("pad_we", 32'(bus_a.mem_we), 32'd1);
        check("pad_addr", 32'(bus_a.mem_addr), 32'd1);
        check("pad_data", bus_a.mem_wdata, 32'h0000_0000);
        check("pad_count", 32'(cnt_a), 32'd2);
        idle_cycle();
        check("pad_done0", 32'(done_a), 32'd0);
        check("pad_we_off", 32'(bus_a.mem_we), 32'd0);
`else
        check("drain_we", 32'(bus_a.mem_we), 32'd0);
        check("drain_count", 32'(cnt_a), 32'd1);
`endif
        idle_cycle();
        check("load_done_pulse", 32'(done_a), 32'd1);
        idle_cycle();
        check("load_done_clear", 32'(done_a), 32'd0);
        check("post_idle_ready", 32'(bus_a.in_ready), 32'd0);

        // Exhaust the 4-slot instance with 5 requests
        do_start();
        for (int k = 1; k <= 4; k++) begin
            send(3'd3, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k));
            check("sm_we", 32'(bus_s.mem_we), 32'd1);
            check("sm_addr", 32'(bus_s.mem_addr), 32'(k - 1));
            check("sm_data", bus_s.mem_wdata, 32'h2001_0000 + 32'(k));
            check("sm_count", 32'(cnt_s), 32'(k));
        end
        check("sm_full", 32'(full_s), 32'd1);
        check("sm_ready_full", 32'(bus_s.in_ready), 32'd0);
        send(3'd3, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5);
        check("sm_5th_held", 32'(bus_s.mem_we), 32'd0);
        check("sm_5th_count", 32'(cnt_s), 32'd4);
        idle_cycle();
        in_valid = 1'b1;
        finish   = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        #1;
        check("sm_drain_we", 32'(bus_s.mem_we), 32'd0);
        check("sm_drain_done0", 32'(done_s), 32'd0);
        @(negedge clk);
        #1;
        check("sm_load_done", 32'(done_s), 32'd1);
        check("sm_final_count", 32'(cnt_s), 32'd4);
        check("sm_final_addr", 32'(bus_s.mem_addr), 32'd3);
        idle_cycle();

        // Reset asserted during the write strobe
        do_start();
        send(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005);
        check("rw_we_before", 32'(bus_a.mem_we), 32'd1);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("rw_we_killed", 32'(bus_a.mem_we), 32'd0);
        check("rw_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        idle_cycle();
        check("rw_ready_idle", 32'(bus_a.in_ready), 32'd0);
        check("rw_we_idle", 32'(bus_a.mem_we), 32'd0);
        check("rw_addr", 32'(bus_a.mem_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS instruction encoder and program loader. It is the producing end of the opcode/funct decode path. It accepts symbolic instruction requests over a valid/ready handshake, packs them into 32-bit MIPS words using the same opcode/funct set the decoder recognises, and writes them to consecutive instruction-memory addresses. It sits between the test/boot host and instruction memory.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; rewinds the loader and enters LOAD
- finish  in  1  pulse; ends the load session
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- op_sel  in  3  0 sll, 1 or, 2 add, 3 addi, 4 andi, 5 sw, 6 lw, 7 illegal
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate / offset
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded word
- instr_count  out  ADDR_WIDTH+1  words written this session
- full  out  1  memory space exhausted
- err_illegal  out  1  sticky; an illegal op_sel was accepted
- load_done  out  1  one-cycle pulse when the session closes

## Operation
- FSM states: IDLE, LOAD, DRAIN, FULL.
- IDLE → LOAD on `start`.
- LOAD → FULL when instr_count reaches 2^ADDR_WIDTH.
- LOAD or FULL → DRAIN on `finish`.
- DRAIN → IDLE once no write is pending; `load_done` pulses on that transition.
- `start` in any state clears the session and goes to LOAD:
  - address reloads to BASE_ADDR
  - instr_count, full and err_illegal clear
  - any pending write is cancelled
- `start` has priority over `finish` and over a handshake in the same cycle.
- in_ready = (state==LOAD) && !start && !finish.
- R-type words (op 0–2) are {6'h00, rs, rt, rd, shamt, funct}, with funct = 0x00 / 0x25 / 0x20.
- sll forces rs=0. or/add force shamt=0.
- I-type words (op 3–6) are {opcode, rs, rt, imm}, with opcode = 0x08 / 0x0C / 0x2B / 0x23. rd and shamt are ignored.
- Illegal op 7: the request is consumed and err_illegal sets. No write is issued, and address and count do not change.
- Address and count advance by one per issued write. The address wraps modulo 2^ADDR_WIDTH, but FULL blocks any write past the last slot.

## Timing
- Accept at edge N. Encoded word registered at N. mem_we high for the cycle after N, with mem_addr and mem_wdata valid in that cycle.
- Back-to-back accepts allowed: one write per cycle, full throughput.
- The accept that fills the last slot raises `full` and drops in_ready from the next cycle.
- `finish` in the same cycle as a pending write: the write still issues; load_done follows one cycle later.
- Reset values:
  - state IDLE, in_ready 0, mem_we 0
  - mem_addr BASE_ADDR, mem_wdata 0
  - instr_count 0, full 0, err_illegal 0, load_done 0
- Reset asserted mid-write kills the strobe immediately (asynchronous).

## Configuration
- Macro: `ENCODER_NOP_PAD_EN`.
- Defined: on `finish` with space remaining, DRAIN writes one terminator word 0x00000000 after the last instruction. This adds one cycle before load_done, and instr_count includes the pad. If full, no pad is written.
- Undefined: no pad; finish-to-IDLE behaves as above.

## Structure
- Shared package `mips_isa_pkg`:
  - opcode constants (ADDI, ANDI, SW, LW, RTYPE)
  - funct constants (SLL, OR, ADD)
  - op_sel enum typedef
  - FSM state typedef
- The decoder reuses the same constants.
- Sub-module `instr_field_packer`: purely combinational op_sel+fields → 32-bit word plus `illegal` flag. The FSM, counters and output registers stay in the top.

## Test plan
- start; addi rs=0 rt=8 imm=0x0005 → mem_we next cycle, addr 0, wdata 0x20080005, instr_count 1.
- add rs=9 rt=10 rd=8 then sll rt=9 rd=8 shamt=2 (rs=7 supplied) back-to-back → 0x012A4020 @0, 0x00094080 @1 on consecutive cycles.
- lw rt=8 rs=29 imm=4, then sw rt=8 rs=29 imm=8 → 0x8FA80004, 0xAFA80008.
- ADDR_WIDTH=2: stream 5 requests → 4 writes at 0–3; full=1 and in_ready=0 after the 4th; the 5th is held until finish → load_done; the 5th is never written.
- op_sel=7 between two adds → err_illegal=1; only 2 writes, at consecutive addresses; then start → err_illegal=0, addr BASE_ADDR.
- reset low during the mem_we cycle → mem_we=0 immediately; after release, state IDLE, in_ready=0; with `ENCODER_NOP_PAD_EN`, 1 instr + finish → pad 0x00000000 @1, count 2.
